// File: rtl/snn_image_loader_if.sv
// Signal bundle between the image loader and its surroundings: UART rx/tx,
// the SNN core's input RAM write port, and the core start/done handshake.
interface snn_image_loader_if;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic [9:0] ram_addr;
    logic       ram_data;
    logic       ram_we;
    logic       load_active;
    logic       snn_start;
    logic       snn_done;
    logic [3:0] digit;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       overrun;

    // Environment side: UART receiver/transmitter, core and RAM mux.
    modport master (
        output rx_data, rx_rdy, snn_done, digit, tx_done,
        input  ram_addr, ram_data, ram_we, load_active, snn_start,
        input  tx_data, tx_start, overrun
    );

    // Loader side.
    modport slave (
        input  rx_data, rx_rdy, snn_done, digit, tx_done,
        output ram_addr, ram_data, ram_we, load_active, snn_start,
        output tx_data, tx_start, overrun
    );
endinterface

// File: rtl/snn_image_loader.sv
// Unpacks UART image bytes into 1-bit input-RAM writes (LSB first), kicks the
// SNN core, and returns the classified digit as one ASCII byte.
module snn_image_loader #(
    parameter int unsigned IMG_BYTES = 98
) (
    input  logic                clk,
    input  logic                rst_n,
    snn_image_loader_if.slave   bus
);
    localparam logic [9:0] LAST_PIX = 10'(IMG_BYTES * 8 - 1);

    typedef enum logic [2:0] {LOAD, START, WAIT_CORE, SEND, WAIT_TX} state_t;

    state_t     state, state_next;
    logic [7:0] shift, shift_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic       busy, busy_next;
    logic [7:0] hold, hold_next;
    logic       hold_vld, hold_vld_next;
    logic [9:0] pix, pix_next;
    logic [3:0] digit_lat, digit_lat_next;
    logic [9:0] wr_addr, wr_addr_next;
    logic       wr_data, wr_data_next;
    logic       wr_en, wr_en_next;
    logic       owns_ram, owns_ram_next;
    logic       start_pulse, start_pulse_next;
    logic [7:0] tx_byte, tx_byte_next;
    logic       tx_pulse, tx_pulse_next;
    logic       lost, lost_next;

    // Digits above 9 cannot be a valid class; report them as '?'.
    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            shift       <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            hold        <= '0;
            hold_vld    <= 1'b0;
            pix         <= '0;
            digit_lat   <= '0;
            wr_addr     <= '0;
            wr_data     <= 1'b0;
            wr_en       <= 1'b0;
            owns_ram    <= 1'b1;
            start_pulse <= 1'b0;
            tx_byte     <= '0;
            tx_pulse    <= 1'b0;
            lost        <= 1'b0;
        end else begin
            state       <= state_next;
            shift       <= shift_next;
            bit_cnt     <= bit_cnt_next;
            busy        <= busy_next;
            hold        <= hold_next;
            hold_vld    <= hold_vld_next;
            pix         <= pix_next;
            digit_lat   <= digit_lat_next;
            wr_addr     <= wr_addr_next;
            wr_data     <= wr_data_next;
            wr_en       <= wr_en_next;
            owns_ram    <= owns_ram_next;
            start_pulse <= start_pulse_next;
            tx_byte     <= tx_byte_next;
            tx_pulse    <= tx_pulse_next;
            lost        <= lost_next;
        end
    end

    always_comb begin
        state_next       = state;
        shift_next       = shift;
        bit_cnt_next     = bit_cnt;
        busy_next        = busy;
        hold_next        = hold;
        hold_vld_next    = hold_vld;
        pix_next         = pix;
        digit_lat_next   = digit_lat;
        wr_addr_next     = wr_addr;
        wr_data_next     = wr_data;
        wr_en_next       = 1'b0;
        owns_ram_next    = (state == LOAD);
        start_pulse_next = 1'b0;
        tx_byte_next     = tx_byte;
        tx_pulse_next    = 1'b0;
        lost_next        = lost;

        case (state)
            LOAD: begin
                if (busy) begin
                    wr_en_next   = 1'b1;
                    wr_data_next = shift[0];
                    wr_addr_next = pix;
                    shift_next   = shift >> 1;
                    bit_cnt_next = bit_cnt + 3'd1;
                    pix_next     = pix + 10'd1;
                    if (pix == LAST_PIX) begin
                        // Image complete: stop writing; a late byte parks in hold.
                        pix_next   = '0;
                        busy_next  = 1'b0;
                        state_next = START;
                        if (bus.rx_rdy) begin
                            if (!hold_vld) begin
                                hold_next     = bus.rx_data;
                                hold_vld_next = 1'b1;
                            end else begin
                                lost_next = 1'b1;
                            end
                        end
                    end else if (bit_cnt == 3'd7) begin
                        // Refill without a bubble, from hold first, else from the wire.
                        if (hold_vld) begin
                            shift_next    = hold;
                            hold_vld_next = 1'b0;
                            if (bus.rx_rdy) begin
                                hold_next     = bus.rx_data;
                                hold_vld_next = 1'b1;
                            end
                        end else if (bus.rx_rdy) begin
                            shift_next = bus.rx_data;
                        end else begin
                            busy_next = 1'b0;
                        end
                    end else if (bus.rx_rdy) begin
                        if (!hold_vld) begin
                            hold_next     = bus.rx_data;
                            hold_vld_next = 1'b1;
                        end else begin
                            lost_next = 1'b1;
                        end
                    end
                end else if (bus.rx_rdy) begin
                    shift_next   = bus.rx_data;
                    bit_cnt_next = '0;
                    busy_next    = 1'b1;
                end
            end
            START: begin
                start_pulse_next = 1'b1;
                state_next       = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (bus.snn_done) begin
                    digit_lat_next = bus.digit;
                    state_next     = SEND;
                end
            end
            SEND: begin
                tx_pulse_next = 1'b1;
                tx_byte_next  = to_ascii(digit_lat);
                state_next    = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.tx_done) begin
                    state_next    = LOAD;
                    lost_next     = 1'b0;
                    hold_vld_next = 1'b0;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    assign bus.ram_addr    = wr_addr;
    assign bus.ram_data    = wr_data;
    assign bus.ram_we      = wr_en;
    assign bus.load_active = owns_ram;
    assign bus.snn_start   = start_pulse;
    assign bus.tx_data     = tx_byte;
    assign bus.tx_start    = tx_pulse;
    assign bus.overrun     = lost;
endmodule

// File: doc/snn_image_loader.md
# snn_image_loader

Write-side companion to the SNN core's 784x1 input RAM. Accepts image bytes from the UART receiver and unpacks each byte to 8 single-bit RAM writes. After all 98 bytes (784 pixels) are written, it pulses the core's start, waits for done, and sends the classified digit back as one ASCII byte through the UART transmitter. It owns the input RAM port only while loading; `load_active` drives the top-level address mux.

## Interface
- `IMG_BYTES`, 98: bytes per image; 8*IMG_BYTES = 784 = input RAM depth.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received byte; valid only while `rx_rdy`=1.
- `rx_rdy`  in  1  one-cycle pulse, one per received byte.
- `ram_addr`  out  10  input-RAM write address, 0..783.
- `ram_data`  out  1  pixel bit to write.
- `ram_we`  out  1  input-RAM write enable.
- `load_active`  out  1  1 = loader owns the input-RAM address/data/we; 0 = core's `addr_input_unit` owns the address.
- `snn_start`  out  1  one-cycle start pulse to the core.
- `snn_done`  in  1  core completion pulse.
- `digit`  in  4  core result; sampled when `snn_done`=1.
- `tx_data`  out  8  byte to transmit.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_done`  in  1  transmitter finished the byte.
- `overrun`  out  1  sticky; set when a byte is lost during loading.

## Operation
- States: LOAD, START, WAIT_CORE, SEND, WAIT_TX.
- **Bit order.** Byte k maps to addresses 8k..8k+7, LSB first. Bit 0 goes to address 8k.
- **Buffering.** Write path has a shifter (8 bits) plus a bit counter and a 1-deep hold register with a valid flag.
- **LOAD.** `load_active`=1.
  - `rx_rdy` with shifter idle: load the byte into the shifter.
  - `rx_rdy` with shifter busy and hold empty: capture into hold.
  - `rx_rdy` with shifter busy and hold full: drop the byte and set `overrun`.
  - Shifter busy: one write per cycle. `ram_we`=1, `ram_data`=shift[0], `ram_addr` = 10-bit pixel counter. Then shift right and increment the counter.
  - After bit 7 of a byte: if hold is valid, move hold into the shifter so the next cycle writes its bit 0 (no bubble). Otherwise the shifter goes idle.
  - Write of address 783 → START. The pixel counter resets to 0 on that transition.
- **START.** One cycle: `snn_start`=1, `load_active`=0 → WAIT_CORE.
- **WAIT_CORE.** On `snn_done`, latch `digit` → SEND.
  - `rx_rdy` in START, WAIT_CORE, SEND or WAIT_TX: byte discarded. `overrun` is not set.
- **SEND.** One cycle: `tx_start`=1. `tx_data` = 8'h30 + {4'h0, digit_latched} for digit 0..9; 8'h3F ('?') for digit > 9. → WAIT_TX.
- **WAIT_TX.** Hold `tx_data` stable. On `tx_done`: return to LOAD, clear `overrun`, clear hold valid.
- `snn_done` seen outside WAIT_CORE: ignored. `tx_done` seen outside WAIT_TX: ignored.

## Timing
- Reset values: state=LOAD, `ram_addr`=0, `ram_data`=0, `ram_we`=0, `load_active`=1, `snn_start`=0, `tx_start`=0, `tx_data`=8'h00, `overrun`=0. Shifter, hold and counters are cleared.
- All outputs are registered.
- `rx_rdy` sampled at edge t → first write (`ram_we`=1, addr 8k) visible after edge t+1. The last bit of that byte is visible after edge t+8.
- Back-to-back bytes (hold used): 16 consecutive write cycles with no gap.
- Last write (addr 783) visible in cycle c → `snn_start`=1 in cycle c+1 → `load_active`=0 from cycle c+1.
- `snn_done` sampled at edge t → `tx_start`=1 in the cycle after edge t+1 (SEND). It stays high exactly one cycle.
- `rx_rdy` coinciding with the final bit-7 write into an empty hold: the byte goes to the shifter and writes start the next cycle.
- Pixel counter wraps only via the 783→0 transition. It never reaches 784.
- `rst_n` low mid-load or mid-classify: immediate return to the reset values. Partial RAM content is not erased; the next image overwrites it.

## Test plan
- **Single image, spaced bytes.** 98 bytes, 0xA5 repeated, one `rx_rdy` per 20 cycles → 784 writes. Addr 0..7 carry data 1,0,1,0,0,1,0,1. One `snn_start` the cycle after addr 783. `overrun`=0.
- **Back-to-back bytes.** `rx_rdy` 0x01 then 0xFF on consecutive cycles → 16 contiguous writes. Addr 0 =1, addr 1..7 =0, addr 8..15 =1.
- **Overrun.** Three `rx_rdy` in 3 consecutive cycles → third byte dropped and `overrun`=1. After `tx_done`, `overrun`=0.
- **Result path.** Core model returns `digit`=7 with `snn_done` → `tx_start` pulse with `tx_data`=8'h37. Loader returns to LOAD only after `tx_done`. Repeat with `digit`=4'hC → `tx_data`=8'h3F.
- **Ignored traffic.** `rx_rdy` during WAIT_CORE → no `ram_we` and `overrun` stays 0. A stray `tx_done` in WAIT_CORE → no state change.
- **Reset mid-load.** Assert `rst_n`=0 after 40 bytes, then send a full 98-byte image → first write at addr 0, `snn_start` after exactly 784 writes.
